// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: opcodes,
// sequencer command codes, FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    // ALU operation codes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1001;

    // Sequencer-only command codes (1011..1110 behave as READ)
    localparam logic [3:0] CMD_LOAD = 4'b1000;
    localparam logic [3:0] CMD_MUL  = 4'b1010;
    localparam logic [3:0] CMD_READ = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_RESP = 2'b11
    } seq_state_e;

    // True for codes whose result comes straight from the ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        logic hit;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_XOR: hit = 1'b1;
            default:                                hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response valid/ready streams of the ALU sequencer.
interface alu_sequencer_if #(parameter int WIDTH = 6);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_operand;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_operand, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator-based initiator for the combinational ALU. Executes ALU ops,
// LOAD, READ and a shift-and-add MUL built from one ALU ADD per step, and
// returns each accumulator result over a valid/ready response stream.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.slave   bus,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    seq_state_e       state_r, state_next_s;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] operand_r;     // operand B; shifted right as the MUL multiplier
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] prod_r;
    logic             lost_r;
    logic             ovf_r;
    logic [CNT_W-1:0] step_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_carry_r;
    logic             rsp_zero_r;

    logic [WIDTH-1:0] mul_prod_s;
    logic             mul_ovf_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             last_step_s;
    logic             capture_s;

    // The ALU zero flag is redundant: zero is recomputed from the accumulator
    logic             unused_alu_zero_s;
    assign unused_alu_zero_s = alu_zero;

    assign last_step_s = (step_r == LAST_STEP);
    assign capture_s   = (state_r == ST_EXEC) || ((state_r == ST_MUL) && last_step_s);

    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_carry = rsp_carry_r;
    assign bus.rsp_zero  = rsp_zero_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_next_s = (bus.cmd_op == CMD_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_RESP;
            ST_MUL: begin
                if (last_step_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state: handshakes and ALU drive
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_control   = 4'b0000;
        alu_a         = '0;
        alu_b         = '0;
        case (state_r)
            ST_IDLE: bus.cmd_ready = 1'b1;
            ST_EXEC: begin
                alu_control = op_r;
                alu_a       = acc_r;
                alu_b       = operand_r;
            end
            ST_MUL: begin
                alu_control = OP_ADD;
                alu_a       = prod_r;
                alu_b       = mcand_r;
            end
            ST_RESP: bus.rsp_valid = 1'b1;
            default: bus.cmd_ready = 1'b0;
        endcase
    end

    // Result selection: MUL step outcome or single-cycle command result
    always_comb begin
        mul_prod_s = prod_r;
        mul_ovf_s  = ovf_r;
        result_s   = acc_r;
        carry_s    = 1'b0;
        if (operand_r[0]) begin
            mul_prod_s = alu_out;
            mul_ovf_s  = ovf_r | alu_carry | lost_r;
        end else begin
            mul_prod_s = prod_r;
            mul_ovf_s  = ovf_r;
        end
        if (state_r == ST_MUL) begin
            result_s = mul_prod_s;
            carry_s  = mul_ovf_s;
        end else if (is_alu_op(op_r)) begin
            result_s = alu_out;
            carry_s  = alu_carry;
        end else if (op_r == CMD_LOAD) begin
            result_s = operand_r;
            carry_s  = 1'b0;
        end else begin
            result_s = acc_r;
            carry_s  = 1'b0;
        end
    end

    // Command latch, MUL iteration and accumulator/response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= 4'b0000;
            operand_r   <= '0;
            acc_r       <= '0;
            mcand_r     <= '0;
            prod_r      <= '0;
            lost_r      <= 1'b0;
            ovf_r       <= 1'b0;
            step_r      <= '0;
            rsp_data_r  <= '0;
            rsp_carry_r <= 1'b0;
            rsp_zero_r  <= 1'b1;
        end else begin
            if ((state_r == ST_IDLE) && bus.cmd_valid) begin
                op_r      <= bus.cmd_op;
                operand_r <= bus.cmd_operand;
                mcand_r   <= acc_r;
                prod_r    <= '0;
                lost_r    <= 1'b0;
                ovf_r     <= 1'b0;
                step_r    <= '0;
            end else if (state_r == ST_MUL) begin
                prod_r    <= mul_prod_s;
                ovf_r     <= mul_ovf_s;
                operand_r <= operand_r >> 1;
                mcand_r   <= mcand_r << 1;
                lost_r    <= lost_r | mcand_r[WIDTH-1];
                step_r    <= step_r + CNT_W'(1);
            end else begin
                step_r    <= step_r;
            end
            if (capture_s) begin
                acc_r       <= result_s;
                rsp_data_r  <= result_s;
                rsp_carry_r <= carry_s;
                rsp_zero_r  <= (result_s == '0);
            end else begin
                acc_r       <= acc_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU on the alu_* ports,
// directed scenarios followed by randomized commands against a reference model.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic [3:0]   alu_control;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_carry, alu_zero;

    int           vectors;
    int           miscompares;
    logic [W-1:0] ref_acc;
    logic [W-1:0] exp_data;
    logic         exp_carry;
    int           exp_lat;

    alu_sequencer_if #(.WIDTH(W)) bus ();

    alu_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {carry, result}
    function automatic logic [W:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int sh;
        sh = int'(b[2:0]);
        case (op)
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {(a < b), W'(a - b)};
            OP_SLL:  return {1'b0, W'(int'(a) * (2 ** sh))};
            OP_SRL:  return {1'b0, W'(int'(a) / (2 ** sh))};
            OP_SRA:  return {1'b0, W'($signed(a) >>> sh)};
            OP_SLT:  return {1'b0, W'($signed(a) < $signed(b))};
            OP_XOR:  return {1'b0, a ^ b};
            default: return '0;
        endcase
    endfunction

    // The ALU sibling instance, modelled behaviourally
    always_comb begin
        {alu_carry, alu_out} = alu_ref(alu_control, alu_a, alu_b);
        alu_zero = (alu_out == '0);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of one command: updates ref_acc, sets expected response
    task automatic model_apply(input logic [3:0] op, input logic [W-1:0] opnd);
        logic [W:0] r;
        int         p;
        exp_lat = 2;
        if (op == CMD_MUL) begin
            p         = int'(ref_acc) * int'(opnd);
            exp_data  = W'(p % (2 ** W));
            exp_carry = (p >= (2 ** W));
            exp_lat   = W + 1;
        end else if (op == CMD_LOAD) begin
            exp_data  = opnd;
            exp_carry = 1'b0;
        end else if (op <= OP_SLT || op == OP_XOR) begin
            r         = alu_ref(op, ref_acc, opnd);
            exp_data  = r[W-1:0];
            exp_carry = r[W];
        end else begin
            exp_data  = ref_acc;
            exp_carry = 1'b0;
        end
        ref_acc = exp_data;
    endtask

    // Present a command and return at the negedge of the cycle after acceptance
    task automatic issue(input logic [3:0] op, input logic [W-1:0] opnd);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check_val("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_operand = opnd;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for the response, check latency and contents
    task automatic await_rsp();
        int lat;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        check_val("rsp_carry", 32'(bus.rsp_carry), 32'(exp_carry));
        check_val("rsp_zero", 32'(bus.rsp_zero), 32'(exp_data == '0));
    endtask

    // Hold the response for some cycles, then take it
    task automatic take_rsp(input int hold);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("hold_data", 32'(bus.rsp_data), 32'(exp_data));
            check_val("hold_carry", 32'(bus.rsp_carry), 32'(exp_carry));
            check_val("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_val("rsp_released", 32'(bus.rsp_valid), 32'd0);
        check_val("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] opnd, input int hold);
        model_apply(op, opnd);
        bus.rsp_ready = (hold == 0);
        issue(op, opnd);
        await_rsp();
        take_rsp(hold);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check_val("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        check_val("rst_rsp_zero", 32'(bus.rsp_zero), 32'd1);
        check_val("rst_alu_ctl", 32'(alu_control), 32'd0);
        check_val("rst_alu_a", 32'(alu_a), 32'd0);
        check_val("rst_alu_b", 32'(alu_b), 32'd0);
    endtask

    logic [3:0] op_tab [15];

    initial begin
        vectors         = 0;
        miscompares     = 0;
        ref_acc         = '0;
        exp_data        = '0;
        exp_carry       = 1'b0;
        exp_lat         = 0;
        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 4'b0000;
        bus.cmd_operand = '0;
        bus.rsp_ready   = 1'b0;
        for (int i = 0; i < 15; i++) op_tab[i] = (i < 8) ? 4'(i) : 4'(i + 1);

        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios
        run_cmd(CMD_LOAD, 6'd5, 0);
        run_cmd(OP_ADD, 6'd3, 0);
        run_cmd(CMD_LOAD, 6'd63, 1);
        run_cmd(OP_ADD, 6'd1, 0);
        run_cmd(OP_SUB, 6'd1, 0);
        run_cmd(CMD_LOAD, 6'd5, 0);
        run_cmd(CMD_MUL, 6'd6, 0);
        run_cmd(CMD_LOAD, 6'd9, 0);
        run_cmd(CMD_MUL, 6'd8, 0);
        run_cmd(CMD_LOAD, 6'b100000, 0);
        run_cmd(OP_SRA, 6'd2, 0);
        run_cmd(OP_SLT, 6'd1, 0);
        run_cmd(OP_XOR, 6'd63, 0);

        // Backpressure with a second command waiting on the bus
        run_cmd(CMD_LOAD, 6'd9, 0);
        model_apply(CMD_LOAD, 6'd9);
        bus.rsp_ready = 1'b0;
        issue(CMD_LOAD, 6'd9);
        await_rsp();
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = OP_ADD;
        bus.cmd_operand = 6'd20;
        take_rsp(5);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        model_apply(OP_ADD, 6'd20);
        await_rsp();
        take_rsp(0);
        run_cmd(CMD_READ, 6'd0, 0);

        // Reset in the middle of a MUL
        run_cmd(CMD_LOAD, 6'd7, 0);
        issue(CMD_MUL, 6'd5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n   = 1'b1;
        ref_acc = '0;
        run_cmd(CMD_READ, 6'd0, 0);

        // Randomized commands
        for (int i = 0; i < 80; i++) begin
            run_cmd(op_tab[$urandom_range(0, 14)], W'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Accumulator-based command sequencer that acts as the initiator for the 6-bit combinational ALU. It accepts operation commands over a valid/ready stream, drives the ALU's control/operand inputs from registered state, captures result and flags into an accumulator, and returns each result over a valid/ready response stream. It adds LOAD, READ and an iterative MUL that is built from repeated ALU ADDs. It sits between the pin-level command front end and the ALU instance in the top level.

## Interface
- `WIDTH`, 6, datapath width; matches ALU operand width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer accepts a command on `cmd_valid && cmd_ready`.
- `cmd_op` in 4: command code.
- `cmd_operand` in WIDTH: operand B, or the load value.
- `rsp_valid` out 1: response present; held until taken.
- `rsp_ready` in 1: consumer takes the response on `rsp_valid && rsp_ready`.
- `rsp_data` out WIDTH: accumulator after the command.
- `rsp_carry` out 1: carry/overflow flag for the command.
- `rsp_zero` out 1: set when `rsp_data == 0`.
- `alu_control` out 4, `alu_a` out WIDTH, `alu_b` out WIDTH: drive the ALU.
- `alu_out` in WIDTH, `alu_carry` in 1, `alu_zero` in 1: ALU results.

## Operation
- **ALU codes** `cmd_op`: AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, SRA 0110, SLT 0111, XOR 1001.
  - Effect: acc ← ALU(acc, operand); carry ← `alu_carry`.
- **LOAD** 1000: acc ← operand; carry ← 0. The ALU is not used.
- **MUL** 1010: acc ← (acc × operand) mod 2^WIDTH; carry ← 1 iff the full product ≥ 2^WIDTH.
  - Iterates over WIDTH steps, one ALU ADD per step. Partial-product register `prod` starts at 0.
  - At step i, if multiplier bit i = 1: prod ← `alu_out` of ADD(prod, mcand).
  - After each step, mcand is shifted left locally and a sticky `lost` bit is set when a 1 is shifted out.
  - Overflow (sticky) is set when `alu_carry` = 1 on any taken add, or when an add is taken while `lost` = 1.
- **READ** 1111: acc unchanged; carry ← 0.
- Codes 1011–1110 behave as READ.
- `rsp_zero` is recomputed from the new accumulator. `alu_zero` is ignored.
- **FSM states**: IDLE, EXEC, MUL, RESP.
  - IDLE → EXEC on acceptance of an ALU/LOAD/READ code.
  - IDLE → MUL on acceptance of MUL. Acceptance latches op and operand.
  - EXEC → RESP after one cycle; acc and flags are captured at that edge.
  - MUL → RESP after WIDTH cycles.
  - RESP → IDLE on `rsp_ready`.
- `cmd_ready` = 1 only in IDLE.
- `alu_*` outputs:
  - EXEC: driven from latched op, acc and operand.
  - MUL: control = ADD.
  - IDLE/RESP: control = 0000, a = b = 0.

## Timing
- **Reset values**: acc = 0; `rsp_data` = 0, `rsp_carry` = 0, `rsp_zero` = 1; `rsp_valid` = 0; `cmd_ready` = 1; `alu_*` = 0; state IDLE.
- **Reset mid-operation**: aborts immediately. A pending command or response is discarded.
- **Latency**, counted from the acceptance edge E:
  - Non-MUL: `rsp_valid` rises at E+2.
  - MUL: `rsp_valid` rises at E+WIDTH+1.
- **Response stability**: `rsp_data`/`rsp_carry`/`rsp_zero` are registered and stable while `rsp_valid` = 1.
- **Back-to-back**: if `rsp_ready` = 1 when `rsp_valid` rises, the response is taken at that edge and `cmd_ready` returns next cycle. Peak throughput is one non-MUL command per 3 cycles.
- **Backpressure**: `cmd_valid` is ignored while `cmd_ready` = 0. No command is dropped or duplicated.
- **Width rules**: all arithmetic wraps modulo 2^WIDTH. The shift amount is `operand[$clog2(WIDTH)-1:0]`, applied by the ALU.

## Structure
- Shared package `alu_pkg`:
  - ALU opcode constants (AND…XOR).
  - Sequencer command codes LOAD/MUL/READ.
  - FSM state enum.
  - WIDTH default.
- No sub-module. The ALU stays a sibling instance in the top level, wired to the `alu_*` ports.
- The MUL step counter is `$clog2(WIDTH)+1` bits.

## Test plan
- LOAD 5, then ADD 3 → `rsp_data` = 8, carry 0, zero 0, `rsp_valid` at E+2.
- LOAD 63, ADD 1 → data 0, carry 1, zero 1. Then SUB 1 → data 63, carry 1.
- LOAD 5, MUL 6 → data 30, carry 0, `rsp_valid` at E+7. LOAD 9, MUL 8 → data 8, carry 1.
- LOAD 6'b100000, SRA 2 → 6'b111000. SLT 1 (acc negative) → 1. XOR 63 → 62.
- Hold `rsp_ready` = 0 for 5 cycles with `cmd_valid` = 1 → response stable, `cmd_ready` = 0, the second command is accepted only after the handshake.
- Assert `rst_n` = 0 in the middle of MUL → all outputs at reset values. READ afterwards → data 0, zero 1.
